// File: rtl/sz_pkg.sv
// Shared types and default widths for the sz stream controller slice.
package sz_pkg;

    localparam int SZ_WIDTH = 32;
    localparam int SZ_CNT_W = 32;

    // Job sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sz_stream_if.sv
// Stream bundle between the read FIFO, the controller and sz_inner.
// master: the controller side; slave: the environment (FIFO + sz_inner + sink).
interface sz_stream_if
    import sz_pkg::*;
#(
    parameter int WIDTH = SZ_WIDTH
) ();

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             src_ready;
    logic             sink_afull;
    logic [WIDTH-1:0] sz_data_in;
    logic             sz_enable;
    logic             sz_hold;
    logic             sz_out_valid;

    modport master (
        input  src_valid, src_data, sink_afull, sz_out_valid,
        output src_ready, sz_data_in, sz_enable, sz_hold
    );

    modport slave (
        output src_valid, src_data, sink_afull, sz_out_valid,
        input  src_ready, sz_data_in, sz_enable, sz_hold
    );

endinterface

// File: rtl/sz_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sz_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count register: clear, else increment until all ones, then hold.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sz_stream_ctrl.sv
// Job sequencer for sz_inner: meters source words into the pipeline, follows
// downstream backpressure, counts results and reports done/err after drain.
// Optional build macro SZ_STREAM_CTRL_PERF_EN adds perf_cycles/perf_stall.
module sz_stream_ctrl
    import sz_pkg::*;
#(
    parameter int WIDTH         = SZ_WIDTH,
    parameter int CNT_W         = SZ_CNT_W,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_elems,
    sz_stream_if.master      bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] in_cnt,
    output logic [CNT_W-1:0] out_cnt
`ifdef SZ_STREAM_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    // Timer value in the last idle cycle before the timeout fires.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] drain_tmr;
    logic [WIDTH-1:0] data_q;
    logic             enable_q;
    logic             hold_q;

    logic active, start_ok, accept, last_accept;
    logic count_result, overrun, timeout, drain_clr, stall;

    assign active       = (state == ST_RUN) || (state == ST_DRAIN);
    assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign bus.src_ready = (state == ST_RUN) && !bus.sink_afull && (in_cnt < len);
    assign accept       = bus.src_valid && bus.src_ready;
    assign last_accept  = accept && (in_cnt == len - 1'b1);
    assign stall        = (state == ST_RUN) && bus.src_valid && !bus.src_ready;

    // A result is counted only while a job is live and not yet complete;
    // anything else is an overrun.
    assign count_result = bus.sz_out_valid && active && (out_cnt != len);
    assign overrun      = bus.sz_out_valid && !count_result;

    // Drain timer is held at zero outside DRAIN and restarted by every result.
    assign drain_clr = (state != ST_DRAIN) || bus.sz_out_valid;
    assign timeout   = (state == ST_DRAIN) && !bus.sz_out_valid && !hold_q
                       && (out_cnt != len) && (drain_tmr == TIMEOUT_LAST);

    assign busy           = active;
    assign done           = (state == ST_DONE);
    assign bus.sz_data_in = data_q;
    assign bus.sz_enable  = enable_q;
    assign bus.sz_hold    = hold_q;

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = (num_elems == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (last_accept) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((out_cnt == len) || timeout) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Job length, issue stage, hold copy and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len      <= '0;
            data_q   <= '0;
            enable_q <= 1'b0;
            hold_q   <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (start_ok) len <= num_elems;
            if (accept)   data_q <= bus.src_data;
            enable_q <= accept;
            hold_q   <= bus.sink_afull && ((state_next == ST_RUN) || (state_next == ST_DRAIN));
            if (start_ok)                err <= 1'b0;
            else if (overrun || timeout) err <= 1'b1;
        end
    end

    sz_sat_cnt #(.W(CNT_W)) u_in_cnt (
        .clk(clk), .rst(rst), .clr(start_ok), .inc(accept), .cnt(in_cnt)
    );

    sz_sat_cnt #(.W(CNT_W)) u_out_cnt (
        .clk(clk), .rst(rst), .clr(start_ok), .inc(count_result), .cnt(out_cnt)
    );

    sz_sat_cnt #(.W(CNT_W)) u_drain_tmr (
        .clk(clk), .rst(rst), .clr(drain_clr), .inc(!hold_q), .cnt(drain_tmr)
    );

`ifdef SZ_STREAM_CTRL_PERF_EN
    sz_sat_cnt #(.W(CNT_W)) u_perf_cycles (
        .clk(clk), .rst(rst), .clr(start_ok), .inc(active), .cnt(perf_cycles)
    );

    sz_sat_cnt #(.W(CNT_W)) u_perf_stall (
        .clk(clk), .rst(rst), .clr(start_ok), .inc(stall), .cnt(perf_stall)
    );
`else
    logic unused_stall;
    assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_sz_stream_ctrl.sv
// Directed bench for sz_stream_ctrl. A 5-cycle delay line stands in for sz_inner.
// Cycle 0 of a job is the cycle in which start is driven; inputs are driven and
// outputs observed shortly after each rising edge.
module tb_sz_stream_ctrl;
    import sz_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 32;
    localparam int TMO   = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_elems = '0;
    logic             busy, done, err;
    logic [CNT_W-1:0] in_cnt, out_cnt;
`ifdef SZ_STREAM_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_cycles, perf_stall;
`endif

    sz_stream_if #(.WIDTH(WIDTH)) bus ();

    sz_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DRAIN_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_elems(num_elems), .bus(bus),
        .busy(busy), .done(done), .err(err), .in_cnt(in_cnt), .out_cnt(out_cnt)
`ifdef SZ_STREAM_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Per-job observations filled by run_job.
    int n_en, first_en, last_en, done_cyc, busy_cyc, n_res, last_res;
    int rdy_afull, en_hold, hold_err, n_hold, data_err;
    logic [4:0] pipe;

    // Runs one job: start at cycle 0 with num_elems=len, a second start (len 0)
    // at ign_cyc that must be ignored, sink_afull over [afull_lo, afull_hi],
    // at most res_limit results returned from the delay line, one extra result
    // forced in inj_cyc. Stops on done, or when in_cnt reaches stop_in (>=0).
    task automatic run_job(input int len, input int afull_lo, input int afull_hi,
                           input int res_limit, input int inj_cyc, input int ign_cyc,
                           input int stop_in, input logic [WIDTH-1:0] base);
        int   accepted = 0;
        logic afull_prev = 1'b0;
        logic en_now;
        logic from_pipe;
        n_en = 0; first_en = -1; last_en = -1; done_cyc = -1; busy_cyc = 0;
        n_res = 0; last_res = -1; rdy_afull = 0; en_hold = 0; hold_err = 0;
        n_hold = 0; data_err = 0; pipe = '0;
        for (int c = 0; c < 400; c++) begin
            start            = (c == 0) || (c == ign_cyc);
            num_elems        = (c == 0) ? CNT_W'(len) : '0;
            bus.src_valid    = 1'b1;
            bus.src_data     = base + WIDTH'(accepted);
            bus.sink_afull   = (c >= afull_lo) && (c <= afull_hi);
            from_pipe        = pipe[4] && (n_res < res_limit);
            bus.sz_out_valid = from_pipe || (c == inj_cyc);
            #1;
            if (c > 0 && done) begin
                done_cyc = c;
                break;
            end
            if (stop_in >= 0 && in_cnt == CNT_W'(stop_in)) break;
            if (busy) busy_cyc++;
            if (bus.sink_afull && bus.src_ready) rdy_afull++;
            if (bus.sz_enable && bus.sz_hold) en_hold++;
            if (bus.sz_hold) n_hold++;
            if (busy && (bus.sz_hold !== afull_prev)) hold_err++;
            if (bus.sz_enable) begin
                if (bus.sz_data_in !== base + WIDTH'(n_en)) data_err++;
                if (first_en < 0) first_en = c;
                last_en = c;
                n_en++;
            end
            if (from_pipe) begin
                n_res++;
                last_res = c;
            end
            if (bus.src_valid && bus.src_ready) accepted++;
            afull_prev = bus.sink_afull;
            en_now     = bus.sz_enable;
            @(posedge clk);
            #1;
            pipe = {pipe[3:0], en_now};
        end
        start            = 1'b0;
        bus.src_valid    = 1'b0;
        bus.sink_afull   = 1'b0;
        bus.sz_out_valid = 1'b0;
        if (stop_in < 0) check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 64'({bus.src_ready, bus.sz_enable, bus.sz_hold, busy, done, err}), 64'd0);
        check({tag, "_data"}, 64'(bus.sz_data_in), 64'd0);
        check({tag, "_cnts"}, {in_cnt, out_cnt}, 64'd0);
    endtask

    initial begin
        bus.src_valid    = 1'b0;
        bus.src_data     = '0;
        bus.sink_afull   = 1'b0;
        bus.sz_out_valid = 1'b0;
        #2 rst = 1'b0;
        #20;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: len 8, steady source; accepts cycles 1-8, enables 2-9, results 7-14,
        // DRAIN 9-15, DONE in cycle 16. A start in cycle 3 must be ignored.
        run_job(8, -1, -2, 8, -1, 3, -1, 32'h1000_0000);
        check("s1_enables", n_en, 8);
        check("s1_first_en", first_en, 2);
        check("s1_en_consecutive", last_en - first_en, 7);
        check("s1_done_cycle", done_cyc, 16);
        check("s1_busy_cycles", busy_cyc, 15);
        check("s1_counts", {in_cnt, out_cnt}, {32'd8, 32'd8});
        check("s1_err", 64'(err), 64'd0);
        check("s1_data", data_err, 0);

        // 2: len 16, sink_afull cycles 4-9; hold high 5-10, accepts 1-3 and 10-22,
        // last result cycle 28, DONE in cycle 30, busy cycles 1-29.
        run_job(16, 4, 9, 16, -1, -1, -1, 32'h2000_0000);
        check("s2_ready_in_afull", rdy_afull, 0);
        check("s2_enable_in_hold", en_hold, 0);
        check("s2_hold_cycles", n_hold, 6);
        check("s2_hold_follows", hold_err, 0);
        check("s2_enables", n_en, 16);
        check("s2_done_cycle", done_cyc, 30);
        check("s2_counts", {in_cnt, out_cnt}, {32'd16, 32'd16});
        check("s2_err", 64'(err), 64'd0);
        check("s2_data", data_err, 0);
`ifdef SZ_STREAM_CTRL_PERF_EN
        check("s2_perf_stall", perf_stall, 6);
        check("s2_perf_cycles", perf_cycles, 29);
        check("s2_perf_vs_busy", perf_cycles, busy_cyc);
`endif

        // 3: len 4, only 3 results (cycles 7-9). Cycles 10-41 are the 32 idle
        // cycles allowed; DONE with err in cycle 42.
        run_job(4, -1, -2, 3, -1, -1, -1, 32'h3000_0000);
        check("s3_results", n_res, 3);
        check("s3_last_result", last_res, 9);
        check("s3_done_cycle", done_cyc, 42);
        check("s3_err", 64'(err), 64'd1);
        check("s3_counts", {in_cnt, out_cnt}, {32'd4, 32'd3});

        // 4: len 0 from DONE: DONE again next cycle, counters and err cleared.
        run_job(0, -1, -2, 0, -1, -1, -1, 32'h4000_0000);
        check("s4_done_cycle", done_cyc, 1);
        check("s4_enables", n_en, 0);
        check("s4_err_clear", 64'(err), 64'd0);
        check("s4_counts", {in_cnt, out_cnt}, 64'd0);
        bus.sz_out_valid = 1'b1;
        @(posedge clk);
        #1 bus.sz_out_valid = 1'b0;
        check("s4_err_overrun", 64'(err), 64'd1);
        check("s4_out_not_counted", 64'(out_cnt), 64'd0);

        // 5: reset mid-RUN once in_cnt reaches 5, then a clean len 2 job
        // (enables 2-3, results 7-8, DONE in cycle 10).
        run_job(8, -1, -2, 8, -1, -1, 5, 32'h5000_0000);
        check("s5_in_reached", 64'(in_cnt), 64'd5);
        rst = 1'b0;
        #1;
        check_all_zero("s5_reset");
        @(posedge clk);
        #1 rst = 1'b1;
        run_job(2, -1, -2, 2, -1, -1, -1, 32'h5100_0000);
        check("s5_done_cycle", done_cyc, 10);
        check("s5_counts", {in_cnt, out_cnt}, {32'd2, 32'd2});
        check("s5_err", 64'(err), 64'd0);
        check("s5_data", data_err, 0);

        // 6: len 1 with a result forced in the accept cycle: both counters reach 1
        // together, DRAIN in cycle 2, DONE in cycle 3.
        run_job(1, -1, -2, 0, 1, -1, -1, 32'h6000_0000);
        check("s6_done_cycle", done_cyc, 3);
        check("s6_counts", {in_cnt, out_cnt}, {32'd1, 32'd1});
        check("s6_enables", n_en, 1);
        check("s6_err", 64'(err), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
